// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - registered N-input arbitrating mux with valid/ready handshakes; ARB_MUX_RR_EN selects round-robin arbitration
module arb_mux #(
    parameter int WIDTH      = 64,
    parameter int NUM_INPUTS = 4,
    localparam int SEL_W     = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_src,
    input  logic                        out_ready
);

    localparam logic [SEL_W-1:0]      LAST_IDX = SEL_W'(NUM_INPUTS - 1);
    localparam logic [NUM_INPUTS-1:0] ONE_HOT0 = NUM_INPUTS'(1);

    logic             load;
    logic             any_valid;
    logic             transfer;
    logic [SEL_W-1:0] winner;
    logic [WIDTH-1:0] win_data;

    // The output register can take new data when empty or being drained this cycle
    assign load      = !out_valid || out_ready;
    assign any_valid = |in_valid;
    // Reset gating keeps in_ready low while reset is held, even though load is true then
    assign transfer  = load && any_valid && !reset;

`ifdef ARB_MUX_RR_EN
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(NUM_INPUTS);

    logic [SEL_W-1:0] ptr;

    // Winner is the first valid channel at or after ptr, wrapping modulo NUM_INPUTS
    always_comb begin
        logic           found;
        logic [SEL_W:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            // One extra bit holds ptr+k before the wrap; ptr+k never reaches 2*NUM_INPUTS
            idx = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!found && in_valid[idx[SEL_W-1:0]]) begin
                winner = idx[SEL_W-1:0];
                found  = 1'b1;
            end
        end
    end

    // Pointer moves just past the channel that transferred so it gets lowest priority next
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
    end
`else
    // Fixed priority: scanning from the top down leaves the lowest valid index
    always_comb begin
        winner = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                winner = SEL_W'(i);
            end
        end
    end
`endif

    // Data of the granted channel; only reaches outputs through the register
    always_comb begin
        win_data = in_data[winner*WIDTH +: WIDTH];
    end

    // One-hot grant to the winner only when a transfer actually happens
    assign in_ready = transfer ? (ONE_HOT0 << winner) : '0;

    // Output register: load on transfer, drop valid when drained with nothing waiting, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_src   <= winner;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - self-checking bench for arb_mux (NUM_INPUTS=3, both arbitration builds)
module tb_arb_mux;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int SW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_src;
    int           m_ptr;

    // Values sampled by the most recent apply()
    logic [N-1:0]  act_rdy;
    logic          act_ov;
    logic [W-1:0]  act_od;
    logic [SW-1:0] act_src;

    arb_mux #(.WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Arbitration rule: first valid channel in search order, -1 when none
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
`ifdef ARB_MUX_RR_EN
            int c = (m_ptr + k) % N;
`else
            int c = k;
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ov  = 1'b0;
        m_od  = '0;
        m_src = 0;
        m_ptr = 0;
    endtask

    // One clock: drive at negedge, check ready, step model, check registers after posedge
    task automatic apply(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic ordy);
        logic [W-1:0] d [N];
        int           w;
        logic         ld;
        logic [N-1:0] er;
        d[0] = d0; d[1] = d1; d[2] = d2;
        @(negedge clk);
        in_valid  = v;
        in_data   = {d2, d1, d0};
        out_ready = ordy;
        #1;
        ld = !m_ov || ordy;
        w  = pick(v);
        er = '0;
        if (ld && w >= 0) er[w] = 1'b1;
        act_rdy = in_ready;
        chk("in_ready/model", 32'(in_ready), 32'(er));
        if (ld) begin
            if (w >= 0) begin
                m_ov  = 1'b1;
                m_od  = d[w];
                m_src = w;
                m_ptr = (w + 1) % N;
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        act_ov  = out_valid;
        act_od  = out_data;
        act_src = out_src;
        chk("out_valid/model", 32'(out_valid), 32'(m_ov));
        chk("out_data/model", 32'(out_data), 32'(m_od));
        chk("out_src/model", 32'(out_src), 32'(m_src));
    endtask

    typedef struct {
        logic [N-1:0]  v;
        logic [W-1:0]  d0, d1, d2;
        logic          ordy;
        logic [N-1:0]  e_rdy;
        logic          e_ov;
        logic [W-1:0]  e_od;
        logic [SW-1:0] e_src;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int           exp_src [6];
        logic [N-1:0] rv;
        logic [W-1:0] r0, r1, r2;

        // Single-valid and back-pressure vectors: identical in either arbitration mode
        tbl[0] = '{3'b100, 16'h0000, 16'h0000, 16'h00A5, 1'b1, 3'b100, 1'b1, 16'h00A5, 2'd2};
        tbl[1] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b000, 1'b0, 16'h00A5, 2'd2};
        tbl[2] = '{3'b001, 16'h1111, 16'h0000, 16'h0000, 1'b0, 3'b001, 1'b1, 16'h1111, 2'd0};
        tbl[3] = '{3'b010, 16'h0000, 16'h2222, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h1111, 2'd0};
        tbl[4] = '{3'b100, 16'h0000, 16'h0000, 16'h3333, 1'b0, 3'b000, 1'b1, 16'h1111, 2'd0};
        tbl[5] = '{3'b010, 16'h0000, 16'h2222, 16'h0000, 1'b1, 3'b010, 1'b1, 16'h2222, 2'd1};
        tbl[6] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h2222, 2'd1};
        tbl[7] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b000, 1'b0, 16'h2222, 2'd1};

        // Reset state, with inputs valid so the ready gating is exercised
        reset     = 1'b1;
        in_valid  = 3'b111;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_src", 32'(out_src), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = '0;
        reset    = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].ordy);
            chk($sformatf("tbl[%0d] in_ready", i), 32'(act_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl[%0d] out_valid", i), 32'(act_ov), 32'(tbl[i].e_ov));
            chk($sformatf("tbl[%0d] out_data", i), 32'(act_od), 32'(tbl[i].e_od));
            chk($sformatf("tbl[%0d] out_src", i), 32'(act_src), 32'(tbl[i].e_src));
        end

        // Reset asserted while the output holds a transfer
        apply(3'b010, 16'h0, 16'hBEEF, 16'h0, 1'b0);
        chk("pre-reset out_valid", 32'(act_ov), 32'd1);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset out_data", 32'(out_data), 32'd0);
        chk("midreset out_src", 32'(out_src), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("held reset in_ready", 32'(in_ready), 32'd0);
        chk("held reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = '0;
        reset    = 1'b0;
        model_reset();

        // All channels valid with the consumer always ready
`ifdef ARB_MUX_RR_EN
        exp_src = '{0, 1, 2, 0, 1, 2};
`else
        exp_src = '{0, 0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 6; i++) begin
            apply(3'b111, 16'hA000, 16'hA001, 16'hA002, 1'b1);
            chk($sformatf("allvalid[%0d] out_src", i), 32'(act_src), 32'(exp_src[i]));
            chk($sformatf("allvalid[%0d] in_ready", i), 32'(act_rdy), 32'd1 << exp_src[i]);
            chk($sformatf("allvalid[%0d] out_data", i), 32'(act_od), 32'h0000A000 + 32'(exp_src[i]));
        end

        // Wrap at a non-power-of-two channel count: ch1 moves ptr to 2, then ch0/ch2 contend
        apply(3'b010, 16'h0, 16'h5151, 16'h0, 1'b1);
        chk("wrap setup out_src", 32'(act_src), 32'd1);
        apply(3'b101, 16'hC0C0, 16'h0, 16'hC2C2, 1'b1);
`ifdef ARB_MUX_RR_EN
        chk("wrap first out_src", 32'(act_src), 32'd2);
        chk("wrap first out_data", 32'(act_od), 32'h0000C2C2);
`else
        chk("wrap first out_src", 32'(act_src), 32'd0);
        chk("wrap first out_data", 32'(act_od), 32'h0000C0C0);
`endif
        apply(3'b101, 16'hC0C0, 16'h0, 16'hC2C2, 1'b1);
        chk("wrap second out_src", 32'(act_src), 32'd0);
        chk("wrap second out_data", 32'(act_od), 32'h0000C0C0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rv = N'($urandom_range(0, 7));
            r0 = W'($urandom);
            r1 = W'($urandom);
            r2 = W'($urandom);
            apply(rv, r0, r1, r2, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Registered N-input, WIDTH-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output. It generalises the core's 2:1 select mux. It is used wherever several producers share one downstream consumer, such as a writeback port or a memory request path. The block chooses one valid input per cycle, registers its data and source index, and holds them until the consumer accepts.

## Interface
- WIDTH, default 64: data width per channel.
- NUM_INPUTS, default 4: number of input channels; must be ≥ 2, and need not be a power of two.
- SEL_W (localparam): $clog2(NUM_INPUTS).

- clk  in  1: clock; all state updates on its rising edge.
- reset  in  1: asynchronous, active-high reset.
- in_valid  in  NUM_INPUTS: per-channel valid; bit i belongs to channel i.
- in_data  in  NUM_INPUTS*WIDTH: flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NUM_INPUTS: per-channel ready; combinational.
- out_valid  out  1: output register holds a transfer.
- out_data  out  WIDTH: registered data of the granted channel.
- out_src  out  SEL_W: registered index of the granted channel.
- out_ready  in  1: consumer accepts the output this cycle.

## Operation
- Define `load = !out_valid || out_ready`.
- Winner selection (combinational), made over in_valid:
  - With ARB_MUX_RR_EN defined: search starts at `ptr` and proceeds ptr, ptr+1, … wrapping modulo NUM_INPUTS. The first valid channel wins.
  - Without ARB_MUX_RR_EN: the lowest valid index wins.
- in_ready[i] = load && any(in_valid) && (i == winner). At most one bit is high, and it is never high for a channel whose in_valid is low.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a rising clk edge:
  - **Transfer:** out_data <= in_data[winner], out_src <= winner, out_valid <= 1.
  - **load, no input valid:** out_valid <= 0. out_data and out_src hold their values.
  - **!load** (out_valid && !out_ready): all output registers hold.
- Round-robin pointer (RR only): on a transfer, ptr <= winner+1, or 0 if winner == NUM_INPUTS-1. Otherwise ptr holds.
- Producers must keep in_valid and in_data stable until they are accepted. The block does not check this.
- Indices ≥ NUM_INPUTS never appear on out_src.

## Timing
- Reset values (asynchronous, applied immediately on reset high): out_valid=0, out_data=0, out_src=0, ptr=0.
- in_ready is low whenever reset is high.
- Latency: an input accepted in cycle N is presented on out_data/out_valid from cycle N+1.
- Throughput: one transfer per cycle while out_ready stays high.
- Simultaneous output accept and new input: when out_valid && out_ready and an input is valid in the same cycle, the new data replaces the old with no bubble.
- Back-pressure: while out_valid && !out_ready, all in_ready bits are 0, and out_data/out_src stay bit-stable.
- Combinational paths: in_ready depends on out_ready, in_valid and state. No output depends combinationally on in_data.
- Reset asserted mid-transfer: any pending output is discarded and ptr returns to 0. The first grant after reset release follows the reset ptr.

## Configuration
- **ARB_MUX_RR_EN defined:** round-robin arbitration with the `ptr` register, as above. Fairness: a continuously valid channel is granted within NUM_INPUTS transfers.
- **ARB_MUX_RR_EN undefined:** fixed priority (lowest index wins). No ptr register exists. The interface and handshake timing are identical.

## Test plan
- **Reset:** assert reset mid-stream with out_valid=1 → out_valid=0, out_data=0, out_src=0 immediately; in_ready=0 while reset is high.
- **Single channel, NUM_INPUTS=4:** only in_valid[2]=1, in_data ch2=0xA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_src=2.
- **Round-robin (RR_EN), NUM_INPUTS=3:** all in_valid=1, out_ready=1 for 6 cycles → out_src sequence 0,1,2,0,1,2.
- **Fixed priority (no RR_EN):** all in_valid=1 for 4 cycles → out_src stays 0; in_ready[1], in_ready[2] and in_ready[3] stay 0.
- **Back-pressure:** out_valid=1, out_ready=0 for 3 cycles, inputs toggling → out_data and out_src unchanged and in_ready=0. Raising out_ready for one cycle accepts the next winner with no bubble.
- **Wrap at non-power-of-two, NUM_INPUTS=3, RR_EN:** ptr=2 and only ch0 and ch2 valid → ch2 wins, then ptr=0 and ch0 wins.
